// File: rtl/mc_controller.sv
// Multi-cycle control sequencer for the 16-bit CPU (FETCH/DECODE/EXEC/MEM/WB/FAULT).
// Optional performance counters (instret, stall_cyc) are enabled by defining MC_CTRL_PERF_EN.
package mc_ctrl_pkg;
    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_NOT  = 5'd2,  OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4,  OP_XOR  = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8,  OP_ADDI = 5'd9,  OP_ANDI = 5'd10, OP_ORI  = 5'd11;
    localparam logic [4:0] OP_XORI = 5'd12, OP_LUI  = 5'd13, OP_BEQ  = 5'd14, OP_BNE  = 5'd15;
    localparam logic [4:0] OP_BGT  = 5'd16, OP_BLT  = 5'd17, OP_BGE  = 5'd18, OP_BLE  = 5'd19;
    localparam logic [4:0] OP_BGTU = 5'd20, OP_BLTU = 5'd21, OP_BGEU = 5'd22, OP_BLEU = 5'd23;
    localparam logic [4:0] OP_JAL  = 5'd24, OP_LAD  = 5'd25, OP_LOA  = 5'd26, OP_LW   = 5'd27;
    localparam logic [4:0] OP_SW   = 5'd28;

    localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_NOT = 5'd2,  ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4,  ALU_XOR = 5'd5,  ALU_SLL = 5'd6,  ALU_SRL = 5'd7;
    localparam logic [4:0] ALU_SRA = 5'd8,  ALU_BSL = 5'd9,  ALU_EQ  = 5'd10, ALU_GRT = 5'd11;
    localparam logic [4:0] ALU_GTE = 5'd12, ALU_LTE = 5'd13, ALU_GTU = 5'd14, ALU_GEU = 5'd15;
    localparam logic [4:0] ALU_LEU = 5'd16;
endpackage

module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4
`ifdef MC_CTRL_PERF_EN
    ,
    parameter int PERF_W      = 16
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_op,
    input  logic       i_comp,
    input  logic       i_instr_valid,
    output logic       o_instr_ready,
    input  logic       i_mem_ready,
    output logic       o_ir_we,
    output logic       o_pc_we,
    output logic       o_sel_pc,
    output logic       o_sum_imm,
    output logic       o_store_pc,
    output logic       o_reg_we,
    output logic       o_alu_imm,
    output logic       o_alu_bypass,
    output logic       o_alu_feedback_in,
    output logic       o_mem_we,
    output logic       o_mem_bypass,
    output logic [4:0] o_alu_ctrl,
    output logic       o_mem_re,
    output logic       o_busy,
    output logic       o_fault
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] o_instret,
    output logic [PERF_W-1:0] o_stall_cyc
`endif
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_t;

    state_t           r_state;
    logic [4:0]       r_op;
    logic [TMO_W-1:0] r_tmo;
    logic             w_taken;

    function automatic logic [4:0] alu_map(input logic [4:0] op);
        case (op)
            OP_SUB:           alu_map = ALU_SUB;
            OP_NOT:           alu_map = ALU_NOT;
            OP_AND, OP_ANDI:  alu_map = ALU_AND;
            OP_OR,  OP_ORI:   alu_map = ALU_OR;
            OP_XOR, OP_XORI:  alu_map = ALU_XOR;
            OP_SLL:           alu_map = ALU_SLL;
            OP_SRL:           alu_map = ALU_SRL;
            OP_SRA:           alu_map = ALU_SRA;
            OP_LUI:           alu_map = ALU_BSL;
            OP_BEQ, OP_BNE:   alu_map = ALU_EQ;
            OP_BGT, OP_BLT:   alu_map = ALU_GRT;
            OP_BGE:           alu_map = ALU_GTE;
            OP_BLE:           alu_map = ALU_LTE;
            OP_BGTU, OP_BLTU: alu_map = ALU_GTU;
            OP_BGEU:          alu_map = ALU_GEU;
            OP_BLEU:          alu_map = ALU_LEU;
            default:          alu_map = ALU_ADD;
        endcase
    endfunction

    // The "less than" branches reuse the greater-than comparators and invert the result.
    assign w_taken = (r_op == OP_BNE || r_op == OP_BLT || r_op == OP_BLTU) ? !i_comp : i_comp;

    always_comb begin
        o_instr_ready     = 1'b0;
        o_ir_we           = 1'b0;
        o_pc_we           = 1'b0;
        o_sel_pc          = 1'b1;
        o_sum_imm         = 1'b0;
        o_store_pc        = 1'b0;
        o_reg_we          = 1'b0;
        o_alu_imm         = 1'b0;
        o_alu_bypass      = 1'b0;
        o_alu_feedback_in = 1'b0;
        o_mem_we          = 1'b0;
        o_mem_bypass      = 1'b0;
        o_mem_re          = 1'b0;
        o_fault           = 1'b0;
        o_alu_ctrl        = alu_map(r_op);
        o_busy            = (r_state != S_FETCH) && (r_state != S_FAULT);
        case (r_state)
            S_FETCH: begin
                o_instr_ready = 1'b1;
                o_ir_we       = i_instr_valid;
            end
            S_EXEC: begin
                if (r_op >= OP_ADDI && r_op <= OP_XORI) begin
                    o_alu_imm         = 1'b1;
                    o_alu_feedback_in = 1'b1;
                end else if (r_op == OP_LUI) begin
                    o_alu_imm = 1'b1;
                end else if (r_op >= OP_BEQ && r_op <= OP_BLEU) begin
                    o_pc_we   = 1'b1;
                    o_sum_imm = w_taken;
                end else if (r_op == OP_JAL) begin
                    o_sel_pc   = 1'b0;
                    o_store_pc = 1'b1;
                    o_reg_we   = 1'b1;
                    o_pc_we    = 1'b1;
                end else if (r_op == OP_LAD) begin
                    o_reg_we     = 1'b1;
                    o_mem_bypass = 1'b1;
                    o_pc_we      = 1'b1;
                end else if (r_op == OP_LOA) begin
                    o_alu_bypass = 1'b1;
                    o_pc_we      = 1'b1;
                end
            end
            S_MEM: begin
                o_mem_re = (r_op == OP_LW);
                o_mem_we = (r_op == OP_SW);
                o_pc_we  = (r_op == OP_SW) && i_mem_ready;
            end
            S_WB: begin
                o_reg_we = 1'b1;
                o_pc_we  = 1'b1;
            end
            S_FAULT: o_fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
            r_op    <= OP_ADD;
            r_tmo   <= '0;
        end else begin
            case (r_state)
                S_FETCH:  if (i_instr_valid) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op    <= i_op;
                    r_state <= (i_op <= OP_SW) ? S_EXEC : S_FAULT;
                end
                S_EXEC: begin
                    if (r_op == OP_LW || r_op == OP_SW) begin
                        r_state <= S_MEM;
                        r_tmo   <= '0;
                    end else if (r_op <= OP_LUI) begin
                        r_state <= S_WB;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    // A completing access takes priority over an expiring timeout.
                    if (i_mem_ready) begin
                        r_state <= (r_op == OP_LW) ? S_WB : S_FETCH;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (r_tmo == TMO_W'(MEM_TIMEOUT - 1)) r_state <= S_FAULT;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                default: r_state <= S_FAULT;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [PERF_W-1:0] r_instret;
    logic [PERF_W-1:0] r_stall_cyc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instret   <= '0;
            r_stall_cyc <= '0;
        end else begin
            if (o_pc_we) r_instret <= r_instret + 1'b1;
            if ((r_state == S_MEM && !i_mem_ready) || (r_state == S_FETCH && !i_instr_valid))
                r_stall_cyc <= r_stall_cyc + 1'b1;
        end
    end

    assign o_instret   = r_instret;
    assign o_stall_cyc = r_stall_cyc;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// Directed-vector bench for mc_controller; checks perf counters when MC_CTRL_PERF_EN is defined.
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] op = OP_ADD;
    logic       comp = 1'b0;
    logic       instr_valid = 1'b0;
    logic       mem_ready = 1'b0;
    logic       instr_ready, ir_we, pc_we, sel_pc, sum_imm, store_pc, reg_we;
    logic       alu_imm, alu_bypass, alu_feedback_in, mem_we, mem_bypass, mem_re, busy, fault;
    logic [4:0] alu_ctrl;
`ifdef MC_CTRL_PERF_EN
    logic [15:0] instret, stall_cyc;
`endif

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    mc_controller dut (
        .i_clk(clk), .i_rst(rst), .i_op(op), .i_comp(comp),
        .i_instr_valid(instr_valid), .o_instr_ready(instr_ready), .i_mem_ready(mem_ready),
        .o_ir_we(ir_we), .o_pc_we(pc_we), .o_sel_pc(sel_pc), .o_sum_imm(sum_imm),
        .o_store_pc(store_pc), .o_reg_we(reg_we), .o_alu_imm(alu_imm),
        .o_alu_bypass(alu_bypass), .o_alu_feedback_in(alu_feedback_in),
        .o_mem_we(mem_we), .o_mem_bypass(mem_bypass), .o_alu_ctrl(alu_ctrl),
        .o_mem_re(mem_re), .o_busy(busy), .o_fault(fault)
`ifdef MC_CTRL_PERF_EN
        , .o_instret(instret), .o_stall_cyc(stall_cyc)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic perf(input string tag, input int exp_ret, input int exp_stall);
`ifdef MC_CTRL_PERF_EN
        chk({tag, "_instret"}, {16'd0, instret}, exp_ret);
        chk({tag, "_stall"}, {16'd0, stall_cyc}, exp_stall);
`endif
    endtask

    // FETCH + DECODE of one instruction; returns one cycle into EXEC (or FAULT).
    task automatic fetch(input logic [4:0] o);
        instr_valid = 1'b1;
        op = o;
        #1;
        chk("fetch_ir_we", ir_we, 1);
        tick();
        instr_valid = 1'b0;
        #1;
        chk("decode_busy", busy, 1);
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ir_we", ir_we, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_sel_pc", sel_pc, 1);
        chk("rst_alu_ctrl", alu_ctrl, ALU_ADD);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        chk("rst_instr_ready", instr_ready, 1);
        perf("rst", 0, 0);

        fetch(OP_ADD);
        #1;
        chk("add_exec_pc_we", pc_we, 0);
        chk("add_exec_alu_imm", alu_imm, 0);
        chk("add_exec_alu_ctrl", alu_ctrl, ALU_ADD);
        chk("add_exec_busy", busy, 1);
        tick();
        #1;
        chk("add_wb_reg_we", reg_we, 1);
        chk("add_wb_pc_we", pc_we, 1);
        chk("add_wb_busy", busy, 1);
        tick();

        fetch(OP_BNE);
        comp = 1'b0;
        #1;
        chk("bne0_pc_we", pc_we, 1);
        chk("bne0_sum_imm", sum_imm, 1);
        chk("bne0_alu_ctrl", alu_ctrl, ALU_EQ);
        tick();
        fetch(OP_BNE);
        comp = 1'b1;
        #1;
        chk("bne1_sum_imm", sum_imm, 0);
        chk("bne1_pc_we", pc_we, 1);
        tick();
        fetch(OP_BLTU);
        comp = 1'b1;
        #1;
        chk("bltu1_sum_imm", sum_imm, 0);
        chk("bltu1_alu_ctrl", alu_ctrl, ALU_GTU);
        tick();
        comp = 1'b0;

        fetch(OP_JAL);
        #1;
        chk("jal_sel_pc", sel_pc, 0);
        chk("jal_store_pc", store_pc, 1);
        chk("jal_reg_we", reg_we, 1);
        tick();
        fetch(OP_ADDI);
        #1;
        chk("addi_alu_imm", alu_imm, 1);
        chk("addi_feedback", alu_feedback_in, 1);
        chk("addi_exec_pc_we", pc_we, 0);
        tick();
        tick();
        perf("pre_lw", 6, 0);

        fetch(OP_LW);
        #1;
        chk("lw_exec_mem_re", mem_re, 0);
        tick();
        cnt = 0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mem_re === 1'b1) cnt++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        if (mem_re === 1'b1) cnt++;
        chk("lw_mem_pc_we", pc_we, 0);
        tick();
        mem_ready = 1'b0;
        chk("lw_mem_re_cycles", cnt, 4);
        #1;
        chk("lw_wb_mem_re", mem_re, 0);
        chk("lw_wb_reg_we", reg_we, 1);
        chk("lw_wb_pc_we", pc_we, 1);
        tick();
        perf("post_lw", 7, 3);

        fetch(OP_SW);
        tick();
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (mem_we === 1'b1) cnt++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        if (mem_we === 1'b1) cnt++;
        chk("edge_sw_pc_we", pc_we, 1);
        tick();
        mem_ready = 1'b0;
        chk("edge_mem_we_cycles", cnt, 15);
        #1;
        chk("edge_fault", fault, 0);
        chk("edge_instr_ready", instr_ready, 1);
        perf("post_edge", 8, 17);

        fetch(OP_SW);
        tick();
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (mem_we === 1'b1) cnt++;
            tick();
        end
        chk("tmo_mem_we_cycles", cnt, 15);
        #1;
        chk("tmo_fault", fault, 1);
        chk("tmo_mem_we", mem_we, 0);
        chk("tmo_instr_ready", instr_ready, 0);
        chk("tmo_busy", busy, 0);
        instr_valid = 1'b1;
        tick();
        tick();
        tick();
        #1;
        chk("tmo_sticky_fault", fault, 1);
        chk("tmo_sticky_ir_we", ir_we, 0);
        chk("tmo_sticky_ready", instr_ready, 0);
        perf("post_tmo", 8, 32);
        instr_valid = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("clr_fault", fault, 0);

        fetch(OP_SW);
        tick();
        #1;
        chk("rstmem_mem_we", mem_we, 1);
        rst = 1'b1;
        tick();
        #1;
        chk("rstmem_mem_we_after", mem_we, 0);
        chk("rstmem_sel_pc", sel_pc, 1);
        chk("rstmem_fault", fault, 0);
        chk("rstmem_instr_ready", instr_ready, 1);
        rst = 1'b0;
        perf("rstmem", 0, 0);

        fetch(5'd31);
        #1;
        chk("illegal_fault", fault, 1);
        chk("illegal_instr_ready", instr_ready, 0);
        chk("illegal_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle successor to the single-cycle CPU control decoder for the 16-bit CPU.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the same datapath control set, plus PC/IR write strobes.
- Adds a ready/valid handshake to instruction fetch, a variable-latency data-memory handshake with a timeout, and a sticky fault state.
- Sits between the instruction register/fetch unit and the datapath (PC mux, register file, ALU, data memory).

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent waiting on mem_ready before entering FAULT (must be ≥1)
TMO_W, 4, timeout counter width; must satisfy 2**TMO_W > MEM_TIMEOUT
PERF_W, 16, width of performance counters (present only with the optional feature)

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
op  in  opcode_t  opcode from the instruction register; sampled in DECODE only
comp  in  1  ALU compare result; valid in EXEC
instr_valid  in  1  fetch unit holds a valid instruction
instr_ready  out  1  controller accepts an instruction this cycle
mem_ready  in  1  data memory has completed the current access
ir_we  out  1  load the instruction register (one-cycle pulse)
pc_we  out  1  update the PC (one pulse per retired instruction)
sel_PC, sum_imm, store_pc, reg_we, alu_imm, alu_bypass, alu_feedback_in, mem_we, mem_bypass  out  1 each  datapath controls, same meaning as the single-cycle set
alu_ctrl  out  alu_opcode_t  ALU operation
mem_re  out  1  data-memory read request
busy  out  1  high in every state except FETCH and FAULT
fault  out  1  sticky illegal-opcode / memory-timeout flag

Behaviour:
- Reset: state=FETCH, op_q=ADD, counters=0. All strobes are 0. sel_PC=1. alu_ctrl=ALU_ADD. fault=0.
- Outputs are a registered-state (Moore) decode of {state, op_q}. Defaults when not stated otherwise: strobes 0, sel_PC=1, alu_ctrl=map(op_q).
- FETCH: instr_ready=1. When instr_valid=1: ir_we=1 → DECODE. Otherwise stay in FETCH.
- DECODE: op_q<=op.
  - Opcode outside the defined set → FAULT.
  - Otherwise → EXEC.
- EXEC:
  - ALU ops (ADD, SUB, NOT, AND, OR, XOR, SLL, SRL, SRA): alu_imm=0 → WB.
  - Immediate ops (ADDI, ANDI, ORI, XORI): alu_imm=1, alu_feedback_in=1 → WB.
  - LUI: alu_imm=1, alu_ctrl=ALU_BSL → WB.
  - Branches: pc_we=1 and sum_imm=taken, then → FETCH.
    - BEQ, BNE use alu_ctrl=EQ. BGT, BLT use GRT. BGE uses GTE. BLE uses LTE.
    - BGTU, BLTU use GTU. BGEU uses GEU. BLEU uses LEU.
    - taken = comp for BEQ/BGT/BGE/BLE/BGTU/BGEU/BLEU; taken = !comp for BNE/BLT/BLTU.
  - JAL: sel_PC=0, store_pc=1, reg_we=1, pc_we=1 → FETCH.
  - LAD: reg_we=1, mem_bypass=1, pc_we=1 → FETCH.
  - LOA: alu_bypass=1, pc_we=1 → FETCH.
  - LW, SW: → MEM, with the timeout counter cleared.
- MEM:
  - Request: mem_re=1 (LW) or mem_we=1 (SW), held every cycle until mem_ready=1.
  - Counter increments on each cycle with mem_ready=0.
  - On mem_ready=1: LW → WB; SW → pc_we=1 → FETCH. mem_ready wins over the timeout when both occur in the same cycle.
  - When the counter reaches MEM_TIMEOUT with mem_ready=0 → FAULT. The request drops the same cycle.
- WB: reg_we=1, pc_we=1 → FETCH.
- FAULT:
  - fault=1, instr_ready=0, all strobes 0.
  - Leaves FAULT only on rst.
- Latency: branch/JAL/LAD/LOA take 3 cycles; ALU ops take 4; LW takes 4+wait; SW takes 3+wait. Exactly one pc_we per instruction.
- rst is checked first and wins over any state, including mid-MEM. Outstanding requests drop the next cycle.
- instr_valid is ignored outside FETCH. comp is ignored outside EXEC.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- Defined:
  - Adds outputs instret[PERF_W] and stall_cyc[PERF_W], both reset to 0.
  - instret increments on each pc_we.
  - stall_cyc increments on each MEM cycle with mem_ready=0, and on each FETCH cycle with instr_valid=0.
  - Both wrap modulo 2**PERF_W; no saturation.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD with instr_valid=1 → ir_we in cycle 1, WB reg_we=1 and pc_we=1 in cycle 4; alu_ctrl=ALU_ADD throughout; busy=1 for cycles 2-4.
- BNE with comp=0 → EXEC pc_we=1, sum_imm=1. BNE with comp=1 → sum_imm=0. BLTU with comp=1 → sum_imm=0.
- LW with mem_ready low for 3 cycles → mem_re=1 for 4 cycles, then WB reg_we=1; instret=+1 and stall_cyc=+3 under MC_CTRL_PERF_EN.
- SW with mem_ready never asserted (MEM_TIMEOUT=15) → mem_we=1 for 15 cycles, then fault=1 and instr_ready=0 persist until rst.
- mem_ready=1 in the same cycle the counter hits MEM_TIMEOUT → normal completion, fault=0.
- rst asserted during MEM (mem_we=1) → next cycle state FETCH, mem_we=0, sel_PC=1, fault=0; an undefined opcode in DECODE → FAULT.
